// File: rtl/spi_regbank_pkg.sv
// Shared command codes and readback status layout for the SPI register bank.
package spi_regbank_pkg;

    localparam logic [7:0] CMD_RESET    = 8'h01;
    localparam logic [7:0] CMD_TURBO    = 8'h02;
    localparam logic [7:0] CMD_KEYS     = 8'h10;
    localparam logic [7:0] CMD_HCTRL    = 8'h11;
    localparam logic [7:0] CMD_KB_WR    = 8'h12;
    localparam logic [7:0] CMD_KB_FLUSH = 8'h13;
    localparam logic [7:0] CMD_VMODE    = 8'h40;
    localparam logic [7:0] CMD_UREG_WR  = 8'h50;
    localparam logic [7:0] CMD_UREG_RD  = 8'h58;
    localparam logic [7:0] CMD_STATUS   = 8'h70;

    localparam int unsigned STAT_CNT_LSB   = 57;
    localparam int unsigned STAT_OVF_BIT   = 56;
    localparam int unsigned STAT_T80_BIT   = 55;
    localparam int unsigned STAT_TURBO_BIT = 54;
    localparam int unsigned STAT_VM_LSB    = 50;

    // Field order matches the bit positions above, MSB first.
    typedef struct packed {
        logic [6:0]  kb_count;
        logic        overflow;
        logic        use_t80;
        logic        force_turbo;
        logic [3:0]  video_mode;
        logic [49:0] rsvd;
    } status_t;

endpackage

// File: rtl/spi_regbank_if.sv
// SPI message-level handshake between the SPI slave front end and the register bank.
interface spi_regbank_if;
    logic        cmd_strobe;
    logic [7:0]  cmd;
    logic        msg_end;
    logic [63:0] rxdata;
    logic [63:0] txdata;
    logic        txdata_valid;

    modport master (
        output cmd_strobe, cmd, msg_end, rxdata,
        input  txdata, txdata_valid
    );

    modport slave (
        input  cmd_strobe, cmd, msg_end, rxdata,
        output txdata, txdata_valid
    );
endinterface

// File: rtl/spi_regbank_kbbuf.sv
// Keyboard byte FIFO; power-of-two depth, a pop frees a slot for a same-cycle push.
module kbbuf_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == CW'(DEPTH));
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    assign rdata  = r_mem[r_rptr];
    assign count  = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wptr] <= wdata;
    end
endmodule

// File: rtl/spi_regbank.sv
// Register bank behind the SPI slave: control outputs, keyboard FIFO, user registers, readback.
module spi_regbank
    import spi_regbank_pkg::*;
#(
    parameter int unsigned NUM_UREGS   = 4,
    parameter int unsigned KBBUF_DEPTH = 16,
    parameter int unsigned RST_PULSE   = 16,
    parameter int unsigned VMODE_W     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    spi_cmd_strobe,
    input  logic [7:0]              spi_cmd,
    input  logic                    spi_msg_end,
    input  logic [63:0]             spi_rxdata,
    output logic [63:0]             spi_txdata,
    output logic                    spi_txdata_valid,
    output logic                    reset_req,
    output logic                    use_t80,
    input  logic                    has_z80,
    output logic                    force_turbo,
    output logic [VMODE_W-1:0]      video_mode,
    output logic [63:0]             keys,
    output logic [7:0]              hctrl1,
    output logic [7:0]              hctrl2,
    output logic [7:0]              kb_rdata,
    output logic                    kb_empty,
    input  logic                    kb_rden,
    output logic [64*NUM_UREGS-1:0] uregs
);
    localparam int unsigned KB_CW = $clog2(KBBUF_DEPTH) + 1;
    localparam int unsigned PW    = 8;

    logic [PW-1:0]    r_pulse_cnt;
    logic             r_use_t80;
    logic             r_overflow;
    logic [63:0]      r_uregs [NUM_UREGS];
    logic             w_kb_push;
    logic             w_kb_pop;
    logic             w_kb_flush;
    logic             w_kb_full;
    logic             w_kb_drop;
    logic [KB_CW-1:0] w_kb_count;
    logic             w_rd_hit;
    logic [63:0]      w_rd_data;
    status_t          w_status;

    assign use_t80    = has_z80 ? r_use_t80 : 1'b1;
    assign w_kb_push  = spi_msg_end && (spi_cmd == CMD_KB_WR);
    assign w_kb_flush = spi_msg_end && (spi_cmd == CMD_KB_FLUSH);
    assign w_kb_pop   = kb_rden && !kb_empty;
    assign w_kb_drop  = w_kb_push && w_kb_full && !w_kb_pop;

    kbbuf_fifo #(
        .DEPTH (KBBUF_DEPTH),
        .WIDTH (8)
    ) u_kbbuf (
        .clk   (clk),
        .reset (reset),
        .push  (w_kb_push),
        .wdata (spi_rxdata[63:56]),
        .pop   (kb_rden),
        .flush (w_kb_flush),
        .rdata (kb_rdata),
        .full  (w_kb_full),
        .empty (kb_empty),
        .count (w_kb_count)
    );

    // Control registers and the stretched reset request; a new 01h restarts the pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reset_req   <= 1'b0;
            r_pulse_cnt <= '0;
            r_use_t80   <= 1'b0;
            force_turbo <= 1'b0;
            video_mode  <= '0;
            keys        <= '1;
            hctrl1      <= 8'hFF;
            hctrl2      <= 8'hFF;
            r_overflow  <= 1'b0;
        end else begin
            if (spi_msg_end && (spi_cmd == CMD_RESET)) begin
                r_use_t80   <= spi_rxdata[56];
                reset_req   <= 1'b1;
                r_pulse_cnt <= PW'(RST_PULSE - 1);
            end else if (r_pulse_cnt != '0) begin
                r_pulse_cnt <= r_pulse_cnt - PW'(1);
            end else begin
                reset_req <= 1'b0;
            end

            if (spi_msg_end) begin
                case (spi_cmd)
                    CMD_TURBO: force_turbo      <= spi_rxdata[56];
                    CMD_KEYS:  keys             <= spi_rxdata;
                    CMD_HCTRL: {hctrl2, hctrl1} <= spi_rxdata[63:48];
                    CMD_VMODE: video_mode       <= spi_rxdata[56 +: VMODE_W];
                    default: begin end
                endcase
            end

            if (spi_msg_end && (spi_cmd == CMD_STATUS)) r_overflow <= 1'b0;
            else if (w_kb_drop)                          r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned n = 0; n < NUM_UREGS; n++) r_uregs[n] <= '0;
        end else begin
            for (int unsigned n = 0; n < NUM_UREGS; n++) begin
                if (spi_msg_end && (spi_cmd == CMD_UREG_WR + 8'(n))) r_uregs[n] <= spi_rxdata;
            end
        end
    end

    for (genvar g = 0; g < NUM_UREGS; g++) begin : g_uregs
        assign uregs[64*g +: 64] = r_uregs[g];
    end

    always_comb begin
        w_status = '{
            kb_count:    7'(w_kb_count),
            overflow:    r_overflow,
            use_t80:     use_t80,
            force_turbo: force_turbo,
            video_mode:  4'(video_mode),
            rsvd:        '0
        };
    end

    // Read decode; unmapped commands leave w_rd_hit low.
    always_comb begin
        w_rd_hit  = 1'b0;
        w_rd_data = '0;
        for (int unsigned n = 0; n < NUM_UREGS; n++) begin
            if (spi_cmd == CMD_UREG_RD + 8'(n)) begin
                w_rd_hit  = 1'b1;
                w_rd_data = r_uregs[n];
            end
        end
        if (spi_cmd == CMD_STATUS) begin
            w_rd_hit  = 1'b1;
            w_rd_data = w_status;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spi_txdata       <= '0;
            spi_txdata_valid <= 1'b0;
        end else if (spi_msg_end) begin
            spi_txdata       <= '0;
            spi_txdata_valid <= 1'b0;
        end else if (spi_cmd_strobe) begin
            spi_txdata       <= w_rd_hit ? w_rd_data : '0;
            spi_txdata_valid <= w_rd_hit;
        end
    end
endmodule

// File: tb/tb_spi_regbank.sv
// Directed bench for spi_regbank: control writes, reset pulse, keyboard FIFO, readback.
module tb_spi_regbank;
    import spi_regbank_pkg::*;

    logic         clk;
    logic         reset;
    logic         has_z80;
    logic         kb_rden;
    logic         reset_req;
    logic         use_t80;
    logic         force_turbo;
    logic [1:0]   video_mode;
    logic [63:0]  keys;
    logic [7:0]   hctrl1;
    logic [7:0]   hctrl2;
    logic [7:0]   kb_rdata;
    logic         kb_empty;
    logic [255:0] uregs;

    int n_checks = 0;
    int n_errors = 0;

    spi_regbank_if bus ();

    spi_regbank #(
        .NUM_UREGS   (4),
        .KBBUF_DEPTH (16),
        .RST_PULSE   (16),
        .VMODE_W     (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .spi_cmd_strobe   (bus.cmd_strobe),
        .spi_cmd          (bus.cmd),
        .spi_msg_end      (bus.msg_end),
        .spi_rxdata       (bus.rxdata),
        .spi_txdata       (bus.txdata),
        .spi_txdata_valid (bus.txdata_valid),
        .reset_req        (reset_req),
        .use_t80          (use_t80),
        .has_z80          (has_z80),
        .force_turbo      (force_turbo),
        .video_mode       (video_mode),
        .keys             (keys),
        .hctrl1           (hctrl1),
        .hctrl2           (hctrl2),
        .kb_rdata         (kb_rdata),
        .kb_empty         (kb_empty),
        .kb_rden          (kb_rden),
        .uregs            (uregs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Full write message; rd drives kb_rden during the msg_end cycle.
    task automatic send_msg(input logic [7:0] c, input logic [63:0] d, input logic rd);
        @(posedge clk); #1;
        bus.cmd        = c;
        bus.rxdata     = d;
        bus.cmd_strobe = 1'b1;
        @(posedge clk); #1;
        bus.cmd_strobe = 1'b0;
        bus.msg_end    = 1'b1;
        kb_rden        = rd;
        @(posedge clk); #1;
        bus.msg_end    = 1'b0;
        kb_rden        = 1'b0;
    endtask

    task automatic read_msg(input logic [7:0] c, input string tag, input logic [63:0] exp_d,
                            input logic exp_v);
        @(posedge clk); #1;
        bus.cmd        = c;
        bus.cmd_strobe = 1'b1;
        @(posedge clk); #1;
        bus.cmd_strobe = 1'b0;
        check({tag, "_valid"}, 64'(bus.txdata_valid), 64'(exp_v));
        check({tag, "_data"}, bus.txdata, exp_d);
        bus.msg_end = 1'b1;
        @(posedge clk); #1;
        bus.msg_end = 1'b0;
        check({tag, "_valid_clr"}, 64'(bus.txdata_valid), 64'd0);
        check({tag, "_data_clr"}, bus.txdata, 64'd0);
    endtask

    // Counts high samples of reset_req over a fixed window starting now.
    task automatic count_pulse(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (reset_req) n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic kb_pop();
        kb_rden = 1'b1;
        @(posedge clk); #1;
        kb_rden = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset          = 1'b1;
        has_z80        = 1'b1;
        kb_rden        = 1'b0;
        bus.cmd_strobe = 1'b0;
        bus.msg_end    = 1'b0;
        bus.cmd        = 8'h00;
        bus.rxdata     = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_keys", keys, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_hctrl", 64'({hctrl2, hctrl1}), 64'hFFFF);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_turbo", 64'(force_turbo), 64'd0);
        check("rst_vmode", 64'(video_mode), 64'd0);
        check("rst_reset_req", 64'(reset_req), 64'd0);
        check("rst_use_t80", 64'(use_t80), 64'd0);
        check("rst_kb_empty", 64'(kb_empty), 64'd1);
        check("rst_txvalid", 64'(bus.txdata_valid), 64'd0);
        check("rst_txdata", bus.txdata, 64'd0);
        check("rst_uregs_lo", uregs[127:0] == '0 ? 64'd0 : 64'd1, 64'd0);
        check("rst_uregs_hi", uregs[255:128] == '0 ? 64'd0 : 64'd1, 64'd0);

        // Reset pulse with hard Z80 fitted and T80 requested
        send_msg(CMD_RESET, 64'h0100_0000_0000_0000, 1'b0);
        check("t80_z80", 64'(use_t80), 64'd1);
        count_pulse(n);
        check("pulse_len_z80", 64'(n), 64'd16);

        has_z80 = 1'b0;
        send_msg(CMD_RESET, 64'h0100_0000_0000_0000, 1'b0);
        check("t80_noz80", 64'(use_t80), 64'd1);
        count_pulse(n);
        check("pulse_len_noz80", 64'(n), 64'd16);

        send_msg(CMD_RESET, 64'h0, 1'b0);
        check("t80_forced", 64'(use_t80), 64'd1);
        count_pulse(n);
        check("pulse_len_q0", 64'(n), 64'd16);
        has_z80 = 1'b1;
        #1;
        check("t80_q0_z80", 64'(use_t80), 64'd0);

        // Control writes
        send_msg(CMD_TURBO, 64'h0100_0000_0000_0000, 1'b0);
        check("turbo", 64'(force_turbo), 64'd1);
        send_msg(CMD_KEYS, 64'hFEDC_BA98_7654_3210, 1'b0);
        check("keys", keys, 64'hFEDC_BA98_7654_3210);
        send_msg(CMD_HCTRL, 64'hA55A_1234_5678_9ABC, 1'b0);
        check("hctrl2", 64'(hctrl2), 64'hA5);
        check("hctrl1", 64'(hctrl1), 64'h5A);
        send_msg(CMD_VMODE, 64'h0600_0000_0000_0000, 1'b0);
        check("vmode", 64'(video_mode), 64'd2);
        read_msg(CMD_STATUS, "status_idle", 64'h0048_0000_0000_0000, 1'b1);

        // User registers
        send_msg(8'h52, 64'h0123_4567_89AB_CDEF, 1'b0);
        check("ureg2_out", uregs[128 +: 64], 64'h0123_4567_89AB_CDEF);
        send_msg(8'h57, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
        check("ureg_oob_hi", uregs[192 +: 64], 64'd0);
        check("ureg_oob_lo", uregs[0 +: 64], 64'd0);
        read_msg(8'h5A, "rd_ureg2", 64'h0123_4567_89AB_CDEF, 1'b1);
        read_msg(8'h5F, "rd_unmapped", 64'd0, 1'b0);

        // Keyboard FIFO overflow
        for (int b = 0; b < 17; b++) send_msg(CMD_KB_WR, {8'(b), 56'h0}, 1'b0);
        check("kb_full_empty", 64'(kb_empty), 64'd0);
        check("kb_head0", 64'(kb_rdata), 64'h00);
        read_msg(CMD_STATUS, "status_ovf", 64'h2148_0000_0000_0000, 1'b1);
        read_msg(CMD_STATUS, "status_ovf_clr", 64'h2048_0000_0000_0000, 1'b1);

        // Push and pop together while full
        send_msg(CMD_KB_WR, 64'hAA00_0000_0000_0000, 1'b1);
        check("kb_head1", 64'(kb_rdata), 64'h01);
        read_msg(CMD_STATUS, "status_pushpop", 64'h2048_0000_0000_0000, 1'b1);
        for (int b = 1; b < 16; b++) begin
            check($sformatf("kb_drain_%0d", b), 64'(kb_rdata), 64'(b));
            kb_pop();
        end
        check("kb_tail", 64'(kb_rdata), 64'hAA);
        kb_pop();
        check("kb_drained", 64'(kb_empty), 64'd1);
        kb_pop();
        send_msg(CMD_KB_WR, 64'h5500_0000_0000_0000, 1'b0);
        check("kb_after_empty_pop", 64'(kb_rdata), 64'h55);
        read_msg(CMD_STATUS, "status_one", 64'h0248_0000_0000_0000, 1'b1);
        send_msg(CMD_KB_FLUSH, 64'h0, 1'b0);
        check("kb_flush", 64'(kb_empty), 64'd1);
        read_msg(CMD_STATUS, "status_flushed", 64'h0048_0000_0000_0000, 1'b1);

        // Reset on cycle 5 of a reset_req pulse
        send_msg(CMD_RESET, 64'h0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("mid_pulse_high", 64'(reset_req), 64'd1);
        reset = 1'b1;
        #1;
        check("abort_reset_req", 64'(reset_req), 64'd0);
        check("abort_keys", keys, 64'hFFFF_FFFF_FFFF_FFFF);
        check("abort_ureg2", uregs[128 +: 64], 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        count_pulse(n);
        check("no_residual_pulse", 64'(n), 64'd0);

        // Reset in the middle of a readback message
        send_msg(8'h52, 64'h1111_2222_3333_4444, 1'b0);
        @(posedge clk); #1;
        bus.cmd        = 8'h5A;
        bus.cmd_strobe = 1'b1;
        @(posedge clk); #1;
        bus.cmd_strobe = 1'b0;
        check("midmsg_valid", 64'(bus.txdata_valid), 64'd1);
        reset = 1'b1;
        #1;
        check("midmsg_abort_valid", 64'(bus.txdata_valid), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midmsg_after_valid", 64'(bus.txdata_valid), 64'd0);
        check("midmsg_after_data", bus.txdata, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spi_regbank.md
SPI_REGBANK -- requirements
Module: spi_regbank

Interface
REQ-001 SHALL have parameter NUM_UREGS, default 4, number of 64-bit user registers (1..8).
REQ-002 SHALL have parameter KBBUF_DEPTH, default 16, keyboard FIFO depth (power of two, 2..64).
REQ-003 SHALL have parameter RST_PULSE, default 16, reset_req pulse length in clk cycles (1..255).
REQ-004 SHALL have parameter VMODE_W, default 2, video mode width (1..4).
REQ-005 SHALL have one clock and an asynchronous, active-high reset; the ports are named clk and reset, and no other clock or reset is used.
REQ-006 SHALL provide these ports:
  clk  in  1  system clock
  reset  in  1  async active-high reset
  spi_cmd_strobe  in  1  one-cycle pulse when the command byte is received
  spi_cmd  in  8  current command, stable from strobe to msg_end
  spi_msg_end  in  1  one-cycle pulse at end of message
  spi_rxdata  in  64  received payload, first byte in [63:56]
  spi_txdata  out  64  readback payload
  spi_txdata_valid  out  1  readback payload valid
  reset_req  out  1  stretched reset request
  use_t80  out  1  CPU select
  has_z80  in  1  hard Z80 fitted
  force_turbo  out  1  turbo enable
  video_mode  out  VMODE_W  video mode
  keys  out  64  keyboard matrix
  hctrl1, hctrl2  out  8 each  hand controllers
  kb_rdata  out  8  FIFO head byte
  kb_empty  out  1  FIFO empty
  kb_rden  in  1  pop the FIFO head
  uregs  out  64*NUM_UREGS  user registers, reg n at [64n+63:64n]

Function
REQ-007 SHALL decode the following commands, each acting only on a cycle where spi_msg_end=1: 01h reset, 02h turbo, 10h keys, 11h hctrl, 12h kb write, 13h kb flush, 40h vidmode, 50h+n write uregs n.
REQ-008 SHALL, for 01h, load use_t80_q from rxdata[56] and drive reset_req high for exactly RST_PULSE cycles starting the next cycle; a new 01h during a pulse SHALL restart the count.
REQ-009 SHALL drive use_t80 as has_z80 ? use_t80_q : 1.
REQ-010 SHALL, for 02h/10h/11h/40h, load force_turbo=rxdata[56], keys=rxdata, {hctrl2,hctrl1}=rxdata[63:48], and video_mode=rxdata[56+VMODE_W-1:56] respectively, each one cycle after msg_end.
REQ-011 SHALL, for 50h+n with n<NUM_UREGS, load uregs n from rxdata; SHALL ignore n>=NUM_UREGS.
REQ-012 SHALL, for 12h, push rxdata[63:56] into the FIFO when it is not full; when full, SHALL drop the byte and set a sticky overflow flag.
REQ-013 SHALL, for 13h, empty the FIFO; overflow is unaffected.
REQ-014 SHALL present the FIFO head combinationally on kb_rdata; kb_rden SHALL pop it and SHALL be ignored when kb_empty=1.
REQ-015 SHALL, on a push and a pop in the same cycle with the FIFO non-empty, perform both and leave the count unchanged; when the FIFO is full, the push SHALL succeed because the pop frees a slot.
REQ-016 SHALL give the FIFO a count width of clog2(KBBUF_DEPTH)+1, with pointers wrapping modulo KBBUF_DEPTH.
REQ-017 SHALL, on a strobe with cmd 58h+n (n<NUM_UREGS), snapshot uregs n into spi_txdata and assert spi_txdata_valid on the next cycle.
REQ-018 SHALL, on a strobe with cmd 70h, snapshot the status word: [63:57] FIFO count, [56] overflow, [55] use_t80, [54] force_turbo, [53:50] video_mode zero-extended, all remaining bits 0; the snapshot SHALL be valid on the next cycle, and overflow SHALL clear at msg_end of a 70h message.
REQ-019 SHALL hold spi_txdata and spi_txdata_valid until spi_msg_end, then drive both to 0 on the next cycle; an unmapped read SHALL leave valid at 0.

Reset
REQ-020 SHALL set, while reset is high: keys=all ones, hctrl1=hctrl2=FFh, force_turbo=0, video_mode=0, use_t80_q=0, uregs=0, reset_req=0, pulse counter=0, FIFO empty, overflow=0, spi_txdata=0, spi_txdata_valid=0.
REQ-021 SHALL, when reset is asserted mid-pulse or mid-message, abort immediately with no residual pulse or readback after release.

Structure
REQ-022 SHALL place the command codes and the status bit positions in the shared package spi_regbank_pkg.
REQ-023 SHALL implement the FIFO as the sub-module kbbuf_fifo (parameters DEPTH and WIDTH=8, ports push/pop/flush/full/empty/count).

Verification
REQ-024 The bench SHALL cover: 01h with rxdata[56]=1, has_z80=1, RST_PULSE=16 -> reset_req high for exactly 16 cycles and use_t80=1; the same with has_z80=0 -> use_t80=1.
REQ-025 The bench SHALL cover: push 17 bytes (00h..10h) with DEPTH=16 -> count=16, overflow=1; a 70h read -> [63:57]=16 and [56]=1; after that message a second 70h -> [56]=0.
REQ-026 The bench SHALL cover: FIFO full with push and kb_rden in the same cycle -> count stays 16, head advances 00h->01h, and the new byte lands at the tail.
REQ-027 The bench SHALL cover: 52h with rxdata=0123456789ABCDEFh, then a 5Ah strobe -> spi_txdata=0123456789ABCDEFh valid one cycle later and cleared the cycle after msg_end; a 5Fh strobe with NUM_UREGS=4 -> valid stays 0.
REQ-028 The bench SHALL cover: reset asserted on cycle 5 of a reset_req pulse -> reset_req=0 at once, keys=all ones, and no pulse after release.
